// File: rtl/cov_pkg.sv
// Shared widths and state encoding for the tap-window stage.
// Pure declarations: no latency, no flow control.
package cov_pkg;
    localparam int DATA_W = 32;
    localparam int TAPS   = 10;
    localparam int IDX_W  = $clog2(TAPS);
    localparam int CNT_W  = $clog2(TAPS + 1);

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        STREAMING
    } state_t;
endpackage

// File: rtl/cov_coef_bank.sv
// TAPS-entry coefficient register file with one write port and a flat read bus.
// Write lands on the next edge; out-of-range addresses are dropped; no backpressure.
module cov_coef_bank
    import cov_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [IDX_W-1:0]         addr,
    input  logic [DATA_W-1:0]        data,
    output logic [TAPS*DATA_W-1:0]   rd_bus
);

    logic [DATA_W-1:0] coef [TAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                coef[k] <= '0;
            end
        end else if (we && (int'(addr) < TAPS)) begin
            coef[addr] <= data;
        end
    end

    always_comb begin
        rd_bus = '0;
        for (int k = 0; k < TAPS; k++) begin
            rd_bus[k*DATA_W +: DATA_W] = coef[k];
        end
    end

endmodule

// File: rtl/cov_tap_window.sv
// Sliding sample window plus coefficient bank, presented as one registered beat.
// Latency 1 edge sample->tap0; s_ready drops while a beat is held; COV_ZERO_PAD_EN emits partial windows.
module cov_tap_window
    import cov_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     coef_we,
    input  logic [IDX_W-1:0]         coef_addr,
    input  logic [DATA_W-1:0]        coef_data,
    output logic                     coef_ready,
    input  logic                     flush,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [TAPS*DATA_W-1:0]   x_win,
    output logic [TAPS*DATA_W-1:0]   h_win
);

`ifdef COV_ZERO_PAD_EN
    localparam bit ZERO_PAD = 1'b1;
`else
    localparam bit ZERO_PAD = 1'b0;
`endif

    localparam logic [CNT_W-1:0] FULL = CNT_W'(TAPS);

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        fill_cnt;
    logic [CNT_W-1:0]        fill_cnt_nxt;
    logic                    m_valid_q;
    logic                    m_valid_nxt;
    logic                    accept;
    logic [TAPS*DATA_W-1:0]  x_q;

    assign s_ready    = !flush && (!m_valid_q || m_ready);
    assign accept     = s_valid && s_ready;
    assign coef_ready = !m_valid_q;
    assign m_valid    = m_valid_q;
    assign x_win      = x_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            fill_cnt  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            fill_cnt  <= fill_cnt_nxt;
            m_valid_q <= m_valid_nxt;
        end
    end

    // Flush beats everything; a new full window beats a downstream pop.
    always_comb begin
        state_nxt    = state;
        fill_cnt_nxt = fill_cnt;
        m_valid_nxt  = m_valid_q;
        if (flush) begin
            state_nxt    = EMPTY;
            fill_cnt_nxt = '0;
            m_valid_nxt  = 1'b0;
        end else begin
            if (accept && (fill_cnt != FULL)) begin
                fill_cnt_nxt = fill_cnt + CNT_W'(1);
            end
            if (accept) begin
                case (state)
                    EMPTY, FILLING: state_nxt = (fill_cnt_nxt == FULL) ? STREAMING : FILLING;
                    default:        state_nxt = state;
                endcase
            end
            if (accept && ((fill_cnt_nxt == FULL) || ZERO_PAD)) begin
                m_valid_nxt = 1'b1;
            end else if (m_ready) begin
                m_valid_nxt = 1'b0;
            end
        end
    end

    // The window register doubles as the output register, so it only moves on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
        end else if (flush) begin
            x_q <= '0;
        end else if (accept) begin
            x_q <= {x_q[(TAPS-1)*DATA_W-1:0], s_data};
        end
    end

    cov_coef_bank u_coef_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (coef_we && coef_ready),
        .addr   (coef_addr),
        .data   (coef_data),
        .rd_bus (h_win)
    );

endmodule

// File: tb/tb_cov_tap_window.sv
// Directed plus randomized bench for cov_tap_window against a queue-based window model.
module tb_cov_tap_window;
    import cov_pkg::*;

`ifdef COV_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    s_valid = 1'b0;
    logic                    s_ready;
    logic [DATA_W-1:0]       s_data = '0;
    logic                    coef_we = 1'b0;
    logic [IDX_W-1:0]        coef_addr = '0;
    logic [DATA_W-1:0]       coef_data = '0;
    logic                    coef_ready;
    logic                    flush = 1'b0;
    logic                    m_valid;
    logic                    m_ready = 1'b0;
    logic [TAPS*DATA_W-1:0]  x_win;
    logic [TAPS*DATA_W-1:0]  h_win;

    always #5 clk = ~clk;

    cov_tap_window dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .coef_ready (coef_ready),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .x_win      (x_win),
        .h_win      (h_win)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: newest-first sample list, fill count, beat flag, coefficient array.
    logic [DATA_W-1:0] mwin[$];
    int                mcnt;
    bit                mmv;
    logic [DATA_W-1:0] mcoef [TAPS];

    function automatic logic [TAPS*DATA_W-1:0] exp_x();
        logic [TAPS*DATA_W-1:0] r = '0;
        for (int k = 0; k < TAPS; k++) begin
            if (k < mwin.size()) r[k*DATA_W +: DATA_W] = mwin[k];
        end
        return r;
    endfunction

    function automatic logic [TAPS*DATA_W-1:0] exp_h();
        logic [TAPS*DATA_W-1:0] r = '0;
        for (int k = 0; k < TAPS; k++) r[k*DATA_W +: DATA_W] = mcoef[k];
        return r;
    endfunction

    task automatic model_reset();
        mwin.delete();
        mcnt = 0;
        mmv  = 1'b0;
        for (int k = 0; k < TAPS; k++) mcoef[k] = '0;
    endtask

    task automatic check(input string tag, input logic [TAPS*DATA_W-1:0] obs,
                         input logic [TAPS*DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic cycle(input logic sv, input logic [DATA_W-1:0] sd, input logic mr,
                         input logic fl, input logic cwe, input logic [IDX_W-1:0] ca,
                         input logic [DATA_W-1:0] cd);
        bit exp_sr;
        bit acc;
        s_valid = sv; s_data = sd; m_ready = mr; flush = fl;
        coef_we = cwe; coef_addr = ca; coef_data = cd;
        #1;
        exp_sr = !fl && (!mmv || mr);
        check("s_ready", s_ready, exp_sr);
        check("coef_ready", coef_ready, !mmv);
        acc = sv && exp_sr;
        if (cwe && !mmv && (int'(ca) < TAPS)) mcoef[ca] = cd;
        if (fl) begin
            mwin.delete();
            mcnt = 0;
            mmv  = 1'b0;
        end else begin
            if (acc) begin
                mwin.push_front(sd);
                if (mwin.size() > TAPS) void'(mwin.pop_back());
                if (mcnt < TAPS) mcnt++;
            end
            if (acc && (mcnt == TAPS || PAD)) mmv = 1'b1;
            else if (mr) mmv = 1'b0;
        end
        @(posedge clk);
        #1;
        check("m_valid", m_valid, mmv);
        check("x_win", x_win, exp_x());
        check("h_win", h_win, exp_h());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1);
    end

    initial begin
        logic [TAPS*DATA_W-1:0] h_before;
        model_reset();
        #2;
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_x_win", x_win, '0);
        check("rst_h_win", h_win, '0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_s_ready", s_ready, 1'b1);
        check("rst_coef_ready", coef_ready, 1'b1);

        // Coefficient writes: in-range lands, out-of-range is ignored.
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, IDX_W'(3), 32'h55);
        check("h_tap3", h_win[3*DATA_W +: DATA_W], 32'h55);
        h_before = h_win;
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, IDX_W'(12), 32'hDEAD_BEEF);
        check("h_addr12_ignored", h_win, h_before);
        for (int k = 0; k < TAPS; k++) begin
            if (k != 3) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, IDX_W'(k), $urandom);
        end

        // Fill with 1..10; beat appears the edge after the 10th accept.
        for (int i = 1; i <= TAPS; i++) cycle(1'b1, DATA_W'(i), 1'b1, 1'b0, 1'b0, '0, '0);
        check("full_m_valid", m_valid, 1'b1);
        check("full_tap0", x_win[0 +: DATA_W], 32'd10);
        check("full_tap9", x_win[9*DATA_W +: DATA_W], 32'd1);

        // Backpressure holds the window, then the release accepts in the same cycle.
        cycle(1'b1, 32'd11, 1'b0, 1'b0, 1'b0, '0, '0);
        check("hold_tap0", x_win[0 +: DATA_W], 32'd10);
        cycle(1'b1, 32'd11, 1'b1, 1'b0, 1'b0, '0, '0);
        check("rel_tap0", x_win[0 +: DATA_W], 32'd11);
        check("rel_tap9", x_win[9*DATA_W +: DATA_W], 32'd2);

        // Coefficient write blocked while a beat is held.
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, IDX_W'(5), 32'h77);

        // Flush while streaming: window cleared, coefficients kept.
        h_before = h_win;
        cycle(1'b1, 32'd99, 1'b1, 1'b1, 1'b0, '0, '0);
        check("flush_x_win", x_win, '0);
        check("flush_m_valid", m_valid, 1'b0);
        check("flush_h_kept", h_win, h_before);
        cycle(1'b1, 32'd7, 1'b1, 1'b0, 1'b0, '0, '0);
        check("first7_tap0", x_win, (TAPS*DATA_W)'(7));
        check("first7_m_valid", m_valid, PAD);
        for (int i = 0; i < TAPS - 1; i++) cycle(1'b1, $urandom, 1'b1, 1'b0, 1'b0, '0, '0);
        check("refill_m_valid", m_valid, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 40) == 0,
                  ($urandom % 4) == 0, IDX_W'($urandom_range(0, 15)), $urandom);
        end

        // Asynchronous reset while a beat is pending.
        for (int i = 0; i < 25 && !mmv; i++) cycle(1'b1, $urandom, 1'b1, 1'b0, 1'b0, '0, '0);
        check("pre_reset_m_valid", m_valid, 1'b1);
        s_valid = 1'b0; m_ready = 1'b0; coef_we = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        check("arst_m_valid", m_valid, 1'b0);
        check("arst_x_win", x_win, '0);
        check("arst_h_win", h_win, '0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 150; i++) begin
            cycle(($urandom % 3) != 0, $urandom, ($urandom % 2) != 0, ($urandom % 60) == 0,
                  ($urandom % 3) == 0, IDX_W'($urandom_range(0, 15)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
